// File: rtl/rc4_decrypt_ctrl.sv
// RC4 decryption sequencer: fills S with the identity permutation, runs the
// key schedule, then generates MSG_LEN keystream bytes and writes the
// decrypted message. Sole master of the S RAM, encrypted ROM and decrypted RAM.
module rc4_decrypt_ctrl #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [MSG_AW-1:0]      rom_addr,
  input  logic [7:0]             rom_rdata,
  output logic [MSG_AW-1:0]      d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren,
  output logic [4:0]             state_dbg
);

  // Handshake: start is a level sampled only in IDLE or DONE; the edge that
  // sees it latches secret_key and busy rises in the following cycle. busy
  // stays high for the whole run, during which start is ignored; done holds
  // in DONE until the next accepted start or reset.

  typedef enum logic [4:0] {
    ST_IDLE, ST_INIT,
    K_RI, K_CJ, K_RJ, K_CS, K_WI, K_WJ,
    P_INC, P_RI, P_CI, P_RJ, P_CJ, P_WI, P_WJ, P_RF, P_CF, P_WD,
    ST_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             i, j, si, sj, f, enc;
  logic [MSG_AW-1:0]      k;
  logic [8*KEY_BYTES-1:0] key_sr;
  logic [7:0]             key_byte;

  // Key bytes are consumed in order byte0, byte1, ... by rotating the
  // latched key left one byte per KSA step, so the top byte is key[i mod KEY_BYTES].
  assign key_byte  = key_sr[8*KEY_BYTES-1 -: 8];
  assign state_dbg = state;

  // State register and datapath registers (i, j, k, swap operands, keystream byte).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      si     <= '0;
      sj     <= '0;
      f      <= '0;
      enc    <= '0;
      key_sr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            key_sr <= secret_key;
            i      <= '0;
            j      <= '0;
            k      <= '0;
          end
        end
        ST_INIT: i <= i + 8'd1;
        K_CJ: begin
          si <= s_rdata;
          j  <= j + s_rdata + key_byte;
        end
        K_CS: sj <= s_rdata;
        K_WJ: begin
          i      <= i + 8'd1;
          key_sr <= (key_sr << 8) | (key_sr >> (8*(KEY_BYTES-1)));
          if (i == 8'd255) begin
            j <= '0;
            k <= '0;
          end
        end
        P_INC: i <= i + 8'd1;
        P_CI: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        P_CJ: sj <= s_rdata;
        P_CF: begin
          f   <= s_rdata;
          enc <= rom_rdata;
        end
        P_WD: k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic and per-state memory strobes; one S access per cycle at most.
  always_comb begin
    state_nxt = state;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    rom_addr  = '0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wren    = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT;
      ST_INIT: begin
        s_wren  = 1'b1;
        s_addr  = i;
        s_wdata = i;
        if (i == 8'd255) state_nxt = K_RI;
      end
      K_RI: begin
        s_addr    = i;
        state_nxt = K_CJ;
      end
      K_CJ: state_nxt = K_RJ;
      K_RJ: begin
        s_addr    = j;
        state_nxt = K_CS;
      end
      K_CS: state_nxt = K_WI;
      K_WI: begin
        s_wren    = 1'b1;
        s_addr    = i;
        s_wdata   = sj;
        state_nxt = K_WJ;
      end
      K_WJ: begin
        s_wren    = 1'b1;
        s_addr    = j;
        s_wdata   = si;
        state_nxt = (i == 8'd255) ? P_INC : K_RI;
      end
      P_INC: state_nxt = P_RI;
      P_RI: begin
        s_addr    = i;
        state_nxt = P_CI;
      end
      P_CI: state_nxt = P_RJ;
      P_RJ: begin
        s_addr    = j;
        state_nxt = P_CJ;
      end
      P_CJ: state_nxt = P_WI;
      P_WI: begin
        s_wren    = 1'b1;
        s_addr    = i;
        s_wdata   = sj;
        state_nxt = P_WJ;
      end
      P_WJ: begin
        s_wren    = 1'b1;
        s_addr    = j;
        s_wdata   = si;
        state_nxt = P_RF;
      end
      // Keystream index uses the pre-swap operands; their sum equals s[i]+s[j] after the swap.
      P_RF: begin
        s_addr    = si + sj;
        rom_addr  = k;
        state_nxt = P_CF;
      end
      P_CF: state_nxt = P_WD;
      P_WD: begin
        d_wren    = 1'b1;
        d_addr    = k;
        d_wdata   = f ^ enc;
        state_nxt = (k == MSG_AW'(MSG_LEN-1)) ? ST_DONE : P_INC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_ctrl.sv
// Directed bench for rc4_decrypt_ctrl: reset, INIT sweep, key byte order,
// i==j swap, end-to-end decrypt against a software RC4 model, start handshake.
module tb_rc4_decrypt_ctrl;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;
  localparam int LAT     = 256 + 1536 + 10*MSG_LEN;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [23:0]       secret_key;
  logic              busy, done;
  logic [7:0]        s_addr, s_wdata, s_rdata;
  logic              s_wren;
  logic [MSG_AW-1:0] rom_addr, d_addr;
  logic [7:0]        rom_rdata, d_wdata;
  logic              d_wren;
  logic [4:0]        state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int d_wr_cnt = 0;
  int wr_base  = 0;

  logic [7:0] s_mem [256];
  logic [7:0] rom   [MSG_LEN];
  logic [7:0] d_mem [MSG_LEN];
  logic [7:0] sw_s  [256];
  logic [7:0] sw_ksa[256];
  logic [7:0] ks    [MSG_LEN];
  logic [7:0] exp_pt[MSG_LEN];
  string      pt_str = "RC4 decrypt controller test msg!";

  rc4_decrypt_ctrl #(.KEY_BYTES(3), .MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // S RAM model: synchronous write, registered read
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata <= s_mem[s_addr];
  end

  // Encrypted ROM model
  always @(posedge clk) rom_rdata <= rom[rom_addr];

  // Decrypted RAM model with write counter
  always @(posedge clk) begin
    if (d_wren) begin
      d_mem[d_addr] <= d_wdata;
      d_wr_cnt      <= d_wr_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Software RC4: KSA snapshot into sw_ksa, keystream into ks
  task automatic sw_rc4(input logic [23:0] key);
    logic [7:0] ii, jj, t, kb;
    for (int n = 0; n < 256; n++) sw_s[n] = n[7:0];
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      case (n % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + sw_s[n] + kb;
      t = sw_s[n]; sw_s[n] = sw_s[jj]; sw_s[jj] = t;
    end
    for (int n = 0; n < 256; n++) sw_ksa[n] = sw_s[n];
    ii = 8'd0;
    jj = 8'd0;
    for (int m = 0; m < MSG_LEN; m++) begin
      ii = ii + 8'd1;
      jj = jj + sw_s[ii];
      t = sw_s[ii]; sw_s[ii] = sw_s[jj]; sw_s[jj] = t;
      t = sw_s[ii] + sw_s[jj];
      ks[m] = sw_s[t];
    end
  endtask

  // Build expected plaintext and encrypt it into the ROM with the current keystream
  task automatic load_rom(input int sel);
    for (int m = 0; m < MSG_LEN; m++) begin
      if (sel == 0) exp_pt[m] = pt_str[m];
      else          exp_pt[m] = 8'(m*37 + 11);
      rom[m] = exp_pt[m] ^ ks[m];
    end
  endtask

  task automatic accept(input logic [23:0] key);
    start      = 1'b1;
    secret_key = key;
    wr_base    = d_wr_cnt;
    step();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic pulse_start(input logic [23:0] key);
    start      = 1'b1;
    secret_key = key;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    while (done !== 1'b1 && (cyc - t0) < LAT + 500) step();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, cyc - t0, LAT);
  endtask

  task automatic check_plain(input string tag);
    check({tag, "_dwrites"}, d_wr_cnt - wr_base, MSG_LEN);
    for (int m = 0; m < MSG_LEN; m++) check({tag, "_pt"}, d_mem[m], exp_pt[m]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_s_addr"}, s_addr, 8'h00);
    check({tag, "_s_wdata"}, s_wdata, 8'h00);
    check({tag, "_s_wren"}, s_wren, 1'b0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_d_addr"}, d_addr, 0);
    check({tag, "_d_wdata"}, d_wdata, 8'h00);
    check({tag, "_d_wren"}, d_wren, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    secret_key = 24'h0;

    // Reset state
    step(); step(); step();
    check_quiet("reset");
    reset_n = 1'b1;
    step();
    check_quiet("idle");

    // INIT sweep and i==j first KSA step with key 0, then S vs software KSA
    sw_rc4(24'h000000);
    load_rom(0);
    accept(24'h000000);
    check("k0_busy", busy, 1'b1);
    for (int n = 0; n < 256; n++) begin
      check("init_wren", s_wren, 1'b1);
      check("init_addr", s_addr, n);
      check("init_wdata", s_wdata, n);
      step();
    end
    check("init_len", s_wren, 1'b0);
    step(); step(); step(); step();
    check("k0_wi_wren", s_wren, 1'b1);
    check("k0_wi_addr", s_addr, 8'h00);
    check("k0_wi_data", s_wdata, 8'h00);
    step();
    check("k0_wj_wren", s_wren, 1'b1);
    check("k0_wj_addr", s_addr, 8'h00);
    check("k0_wj_data", s_wdata, 8'h00);
    while ((cyc - t0) < 1792) step();
    for (int n = 0; n < 256; n++) check("ksa_s", s_mem[n], sw_ksa[n]);
    run_to_done("k0");
    check("k0_busy_end", busy, 1'b0);
    check_plain("k0");

    // Key byte order: restart from DONE with key 010203
    accept(24'h010203);
    check("ko_done_drop", done, 1'b0);
    check("ko_busy", busy, 1'b1);
    while ((cyc - t0) < 260) step();
    check("ko_wi_wren", s_wren, 1'b1);
    check("ko_wi_addr", s_addr, 8'h00);
    check("ko_wi_data", s_wdata, 8'h01);
    step();
    check("ko_wj_wren", s_wren, 1'b1);
    check("ko_wj_addr", s_addr, 8'h01);
    check("ko_wj_data", s_wdata, 8'h00);
    reset_n = 1'b0;
    step();
    check_quiet("ko_abort");
    reset_n = 1'b1;
    step();

    // Reset during INIT cycle 100
    accept(24'h123456);
    while ((cyc - t0) < 100) step();
    check("rst_init_addr", s_addr, 8'd100);
    check("rst_init_wren", s_wren, 1'b1);
    reset_n = 1'b0;
    step();
    check_quiet("rst_mid");
    step();
    check("rst_hold_wren", s_wren, 1'b0);
    step();
    check("rst_hold2_wren", s_wren, 1'b0);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check("rst_after_wren", s_wren, 1'b0);
      check("rst_after_dwren", d_wren, 1'b0);
      check("rst_after_busy", busy, 1'b0);
    end

    // End-to-end with key 000018, start pulses while busy must be ignored
    sw_rc4(24'h000018);
    load_rom(0);
    accept(24'h000018);
    while ((cyc - t0) < 50) step();
    pulse_start(24'hFFFFFF);
    check("ign1_busy", busy, 1'b1);
    while ((cyc - t0) < 1000) step();
    pulse_start(24'hFFFFFF);
    check("ign2_busy", busy, 1'b1);
    run_to_done("e2e");
    check_plain("e2e");

    // Restart from DONE with a new key and a second plaintext
    step();
    check("done_hold", done, 1'b1);
    sw_rc4(24'hA5C3E1);
    load_rom(1);
    accept(24'hA5C3E1);
    check("rerun_done_drop", done, 1'b0);
    check("rerun_busy", busy, 1'b1);
    run_to_done("rerun");
    check_plain("rerun");
    step(); step(); step();
    check("rerun_done_hold", done, 1'b1);
    check("rerun_idle_dwren", d_wren, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
